seq_op_unit: RTL and testbench

Parametrised, registered two-operand arithmetic/logic unit. Generalises the team's fixed 2-bit combinational A/B→C operator to WIDTH bits, with an opcode-selected mode and a multi-cycle shift-add multiply. Operands enter through a valid/ready handshake and results leave through one. Used as a reusable datapath slice behind FPGA top-level wrappers.

---
 rtl/seq_op_pkg.sv | 12 +
 rtl/seq_op_if.sv | 17 +
 rtl/seq_op_mul.sv | 44 ++++
 rtl/seq_op_unit.sv | 71 +++++++
 tb/tb_seq_op_unit.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/seq_op_pkg.sv
// seq_op_pkg: opcode constants and FSM state encoding shared by the seq_op slice.
package seq_op_pkg;
  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_ADD  = 3'd3;
  localparam logic [2:0] OP_SUB  = 3'd4;
  localparam logic [2:0] OP_MUL  = 3'd5;
  localparam logic [2:0] OP_RSV6 = 3'd6;
  localparam logic [2:0] OP_RSV7 = 3'd7;
  typedef enum logic [1:0] {IDLE, MUL, HOLD} state_e;
endpackage

// File: rtl/seq_op_if.sv
// seq_op_if: operand/result valid-ready bus of the seq_op unit.
interface seq_op_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] C;
  logic             ovf;
  logic             err;
  modport master (output in_valid, op, A, B, out_ready,
                  input  in_ready, out_valid, C, ovf, err);
  modport slave  (input  in_valid, op, A, B, out_ready,
                  output in_ready, out_valid, C, ovf, err);
endinterface

// File: rtl/seq_op_mul.sv
// seq_op_mul: iterative shift-add unsigned multiplier, one partial product per cycle.
module seq_op_mul #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic               done,
  output logic [2*WIDTH-1:0] prod
);
  logic [2*WIDTH-1:0] mcand_q, prod_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               busy_q;
  // prod already includes the current step so the parent can capture it on the done edge
  always_comb begin
    prod = prod_q + (mplier_q[0] ? mcand_q : '0);
    done = busy_q && cnt_q == CNT_W'(WIDTH - 1);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else if (start) begin
      mcand_q  <= {{WIDTH{1'b0}}, A};
      prod_q   <= '0;
      mplier_q <= B;
      cnt_q    <= '0;
      busy_q   <= 1'b1;
    end else if (busy_q) begin
      mcand_q  <= mcand_q << 1;
      prod_q   <= prod;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
      busy_q   <= !done;
    end
  end
endmodule

// File: rtl/seq_op_unit.sv
// seq_op_unit: registered WIDTH-bit ALU with valid/ready handshake and multi-cycle multiply.
module seq_op_unit
  import seq_op_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  seq_op_if.slave      bus
);
  state_e             state_q, state_d;
  logic [WIDTH-1:0]   c_q, c_d;
  logic               ovf_q, ovf_d, err_q, err_d;
  logic               accept, mul_start, mul_done;
  logic [2*WIDTH-1:0] mul_prod;
  logic [WIDTH:0]     sum, diff;
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == HOLD;
  assign bus.C         = c_q;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
  seq_op_mul #(.WIDTH(WIDTH)) u_mul (
    .clk  (clk),
    .rst_n(rst_n),
    .start(mul_start),
    .A    (bus.A),
    .B    (bus.B),
    .done (mul_done),
    .prod (mul_prod)
  );
  always_comb begin
    accept    = bus.in_valid && state_q == IDLE;
    mul_start = accept && bus.op == OP_MUL;
    sum       = {1'b0, bus.A} + {1'b0, bus.B};
    diff      = {1'b0, bus.A} - {1'b0, bus.B};
    state_d   = state_q;
    c_d       = c_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    if (accept) state_d = mul_start ? MUL : HOLD;
    if (state_q == MUL && mul_done) state_d = HOLD;
    if (state_q == HOLD && bus.out_ready) state_d = IDLE;
    if (accept && !mul_start) begin
      c_d   = bus.op == OP_AND ? bus.A & bus.B :
              bus.op == OP_OR  ? bus.A | bus.B :
              bus.op == OP_XOR ? bus.A ^ bus.B :
              bus.op == OP_ADD ? sum[WIDTH-1:0] :
              bus.op == OP_SUB ? diff[WIDTH-1:0] : '0;
      ovf_d = bus.op == OP_ADD ? sum[WIDTH] : bus.op == OP_SUB ? diff[WIDTH] : 1'b0;
      err_d = bus.op == OP_RSV6 || bus.op == OP_RSV7;
    end
    if (state_q == MUL && mul_done) begin
      c_d   = mul_prod[WIDTH-1:0];
      ovf_d = |mul_prod[2*WIDTH-1:WIDTH];
      err_d = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      c_q     <= '0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      c_q     <= c_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_seq_op_unit.sv
// tb_seq_op_unit: directed vectors against WIDTH=2 and WIDTH=8 instances.
module tb_seq_op_unit;
  import seq_op_pkg::*;
  logic clk = 1'b0;
  logic rst2_n, rst8_n;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  seq_op_if #(.WIDTH(2)) b2 ();
  seq_op_if #(.WIDTH(8)) b8 ();
  seq_op_unit #(.WIDTH(2)) dut2 (.clk(clk), .rst_n(rst2_n), .bus(b2.slave));
  seq_op_unit #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst8_n), .bus(b8.slave));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    b8.op = op; b8.A = a; b8.B = b; b8.in_valid = 1'b1;
    check("in_ready8", b8.in_ready, 1);
    tick;
    b8.in_valid = 1'b0;
  endtask
  task automatic mul_wait8(input int n);
    for (int i = 0; i < n; i++) begin
      check("mul8_busy_v", b8.out_valid, 0);
      check("mul8_busy_r", b8.in_ready, 0);
      b8.A = 8'h5A ^ 8'(i); b8.B = 8'hC3; b8.op = OP_ADD; b8.in_valid = i[0];
      tick;
    end
    b8.in_valid = 1'b0;
  endtask
  task automatic result8(input string tag, input logic [7:0] c, input logic ovf, input logic err);
    check({tag, "_v"}, b8.out_valid, 1);
    check({tag, "_c"}, b8.C, c);
    check({tag, "_ovf"}, b8.ovf, ovf);
    check({tag, "_err"}, b8.err, err);
    b8.out_ready = 1'b1;
    tick;
    b8.out_ready = 1'b0;
    check({tag, "_done_v"}, b8.out_valid, 0);
    check({tag, "_done_r"}, b8.in_ready, 1);
  endtask
  initial begin
    rst2_n = 1'b0; rst8_n = 1'b0;
    b2.in_valid = 0; b2.op = 0; b2.A = 0; b2.B = 0; b2.out_ready = 0;
    b8.in_valid = 0; b8.op = 0; b8.A = 0; b8.B = 0; b8.out_ready = 0;
    #2;
    check("rst8_ready", b8.in_ready, 1);
    check("rst8_valid", b8.out_valid, 0);
    check("rst8_c", b8.C, 0);
    check("rst8_ovf", b8.ovf, 0);
    check("rst2_ready", b2.in_ready, 1);
    check("rst2_valid", b2.out_valid, 0);
    #20;
    rst2_n = 1'b1; rst8_n = 1'b1;
    tick;
    // WIDTH=2 add with carry
    b2.op = OP_ADD; b2.A = 2'b11; b2.B = 2'b10; b2.in_valid = 1'b1;
    tick;
    b2.in_valid = 1'b0;
    check("add2_v", b2.out_valid, 1);
    check("add2_c", b2.C, 2'b01);
    check("add2_ovf", b2.ovf, 1);
    check("add2_err", b2.err, 0);
    b2.out_ready = 1'b1;
    tick;
    b2.out_ready = 1'b0;
    check("add2_done_v", b2.out_valid, 0);
    // WIDTH=2 multiply: two cycles of latency
    b2.op = OP_MUL; b2.A = 2'd3; b2.B = 2'd2; b2.in_valid = 1'b1;
    tick;
    b2.in_valid = 1'b0;
    check("mul2_v0", b2.out_valid, 0);
    check("mul2_r0", b2.in_ready, 0);
    tick;
    check("mul2_v1", b2.out_valid, 0);
    check("mul2_r1", b2.in_ready, 0);
    tick;
    check("mul2_v", b2.out_valid, 1);
    check("mul2_r", b2.in_ready, 0);
    check("mul2_c", b2.C, 2'b10);
    check("mul2_ovf", b2.ovf, 1);
    b2.out_ready = 1'b1;
    tick;
    b2.out_ready = 1'b0;
    check("mul2_done_r", b2.in_ready, 1);
    // WIDTH=8 directed ops
    send8(OP_SUB, 8'h05, 8'h07);
    result8("sub8", 8'hFE, 1, 0);
    send8(OP_ADD, 8'h12, 8'h34);
    result8("add8", 8'h46, 0, 0);
    send8(OP_AND, 8'hF0, 8'h3C);
    result8("and8", 8'h30, 0, 0);
    send8(OP_OR, 8'hF0, 8'h0C);
    result8("or8", 8'hFC, 0, 0);
    send8(OP_RSV6, 8'hFF, 8'hFF);
    result8("rsv6", 8'h00, 0, 1);
    send8(OP_RSV7, 8'h01, 8'h01);
    result8("rsv7", 8'h00, 0, 1);
    send8(OP_MUL, 8'h0F, 8'h0F);
    mul_wait8(8);
    result8("mul8", 8'hE1, 0, 0);
    send8(OP_MUL, 8'hFF, 8'h02);
    mul_wait8(8);
    result8("mul8_ovf", 8'hFE, 1, 0);
    // backpressure with input churn, then simultaneous in_valid/out_ready
    send8(OP_XOR, 8'hAA, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      b8.A = 8'(i * 37); b8.B = 8'(i * 11); b8.op = OP_ADD; b8.in_valid = ~b8.in_valid;
      tick;
      check("bp_v", b8.out_valid, 1);
      check("bp_c", b8.C, 8'h55);
      check("bp_r", b8.in_ready, 0);
    end
    b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    tick;
    b8.in_valid = 1'b0; b8.out_ready = 1'b0;
    check("bp_done_v", b8.out_valid, 0);
    check("bp_done_r", b8.in_ready, 1);
    check("bp_keep_c", b8.C, 8'h55);
    tick;
    check("bp_no_accept", b8.out_valid, 0);
    // reset during multiply
    send8(OP_MUL, 8'h0F, 8'h0F);
    tick;
    tick;
    tick;
    rst8_n = 1'b0;
    #1;
    check("rstmul_v", b8.out_valid, 0);
    check("rstmul_c", b8.C, 0);
    check("rstmul_r", b8.in_ready, 1);
    tick;
    tick;
    tick;
    rst8_n = 1'b1;
    check("rstmul_hold_v", b8.out_valid, 0);
    tick;
    send8(OP_ADD, 8'h80, 8'h80);
    result8("add8_carry", 8'h00, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
